// File: rtl/img_seq_mmu_if.sv
// img_seq_mmu_if: pixel/gesture/frame-strobe inputs and SDRAM window outputs of img_seq_mmu.
// The slave modport is the sequencer side; the master modport is the controls/SDRAM side.
interface img_seq_mmu_if #(
   parameter int NUM_CH  = 2,
   parameter int MAX_IMG = 16,
   parameter int ADDR_W  = 24
);
   localparam int IDX_W = $clog2(MAX_IMG);

   logic [7:0]               iImg_Tot;
   logic                     iPix_Wr;
   logic                     iGest_E;
   logic                     iGest_W;
   logic                     iNew_Frame;
   logic                     iEnd_Frame;
   logic                     oLoading;
   logic                     oBrowse;
   logic [IDX_W-1:0]         oCur_Img;
   logic [31:0]              oPix_Cnt;
   logic [ADDR_W-1:0]        oWr_Max_Addr;
   logic [NUM_CH*ADDR_W-1:0] oRd_Base;
   logic [NUM_CH*ADDR_W-1:0] oRd_Max;
   logic                     oRd_Load;

   modport slave (
      input  iImg_Tot, iPix_Wr, iGest_E, iGest_W, iNew_Frame, iEnd_Frame,
      output oLoading, oBrowse, oCur_Img, oPix_Cnt, oWr_Max_Addr, oRd_Base, oRd_Max, oRd_Load
   );
   modport master (
      output iImg_Tot, iPix_Wr, iGest_E, iGest_W, iNew_Frame, iEnd_Frame,
      input  oLoading, oBrowse, oCur_Img, oPix_Cnt, oWr_Max_Addr, oRd_Base, oRd_Max, oRd_Load
   );
endinterface

// File: rtl/img_seq_mmu.sv
// img_seq_mmu: slideshow load/settle/browse sequencer with per-channel SDRAM read windows.
// Define AUTO_SLIDE_EN to auto-advance after AUTO_FRAMES gesture-free frames in BROWSE.
module img_seq_mmu #(
   parameter int NUM_CH        = 2,
   parameter int IMG_W         = 800,
   parameter int IMG_H         = 480,
   parameter int WORDS_PER_PIX = 2,
   parameter int MAX_IMG       = 16,
   parameter int ADDR_W        = 24,
   parameter int SETTLE_CYC    = 50,
   parameter int AUTO_FRAMES   = 600
) (
   input  logic          iCLK,
   input  logic          iRST_N,
   img_seq_mmu_if.slave  bus
);
   localparam int IDX_W       = $clog2(MAX_IMG);
   localparam int TOT_W       = IDX_W + 1;
   localparam int PIX_PER_IMG = IMG_W * IMG_H;
   localparam int IMG_WORDS   = PIX_PER_IMG * WORDS_PER_PIX;
   localparam int SET_W       = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_BROWSE = 2'd3;

   localparam logic [1:0] P_NONE  = 2'd0;
   localparam logic [1:0] P_PLUS  = 2'd1;
   localparam logic [1:0] P_MINUS = 2'd2;

   if (longint'(MAX_IMG) * longint'(IMG_WORDS) >= (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("img_seq_mmu: MAX_IMG*IMG_WORDS does not fit in ADDR_W");
   end
   if (AUTO_FRAMES < 1) begin : g_bad_auto
      $error("img_seq_mmu: AUTO_FRAMES must be at least 1");
   end

   logic [1:0]                          state_q, state_d;
   logic [TOT_W-1:0]                    tot_q, tot_d, tot_in;
   logic [31:0]                         pix_q, pix_d, target;
   logic [SET_W-1:0]                    set_q, set_d;
   logic [ADDR_W-1:0]                   wrmax_q, wrmax_d;
   logic [IDX_W-1:0]                    cur_q, cur_d;
   logic [1:0]                          pend_q, pend_d, pend_eff, pend_app;
   logic [NUM_CH-1:0][ADDR_W-1:0]       base_q, max_q;
   logic [ADDR_W-1:0]                   base_w [NUM_CH];
   logic [IDX_W-1:0]                    idx    [NUM_CH];
   logic                                load_q, loading_q, browse_q;
   logic                                in_br, gest_p, gest_m;

   assign tot_in = (32'(bus.iImg_Tot) > 32'(MAX_IMG)) ? TOT_W'(MAX_IMG) : TOT_W'(bus.iImg_Tot);
   assign target = 32'(tot_q) * 32'(PIX_PER_IMG);

   // Counter saturates at target because the transition to SETTLE happens on the reaching pixel.
   always_comb begin
      state_d = state_q;
      tot_d   = tot_q;
      pix_d   = pix_q;
      set_d   = set_q;
      wrmax_d = wrmax_q;
      case (state_q)
         S_IDLE: if (bus.iPix_Wr && bus.iImg_Tot != 8'd0) begin
            tot_d   = tot_in;
            pix_d   = 32'd1;
            wrmax_d = ADDR_W'(tot_in) * ADDR_W'(IMG_WORDS);
            set_d   = '0;
            state_d = (32'(tot_in) * 32'(PIX_PER_IMG) == 32'd1) ? S_SETTLE : S_LOAD;
         end
         S_LOAD: if (bus.iPix_Wr) begin
            pix_d = pix_q + 32'd1;
            if (pix_d == target) begin
               state_d = S_SETTLE;
               set_d   = '0;
            end
         end
         S_SETTLE: begin
            if (set_q == SET_W'(SETTLE_CYC)) state_d = S_BROWSE;
            else                             set_d   = set_q + SET_W'(1);
         end
         default: ;
      endcase
   end

   assign in_br  = (state_q == S_BROWSE);
   assign gest_p = in_br & bus.iGest_W & ~bus.iGest_E;
   assign gest_m = in_br & bus.iGest_E & ~bus.iGest_W;

   // A gesture in the same cycle as frame end overrides the held one and is applied now.
   always_comb begin
      pend_eff = pend_q;
      if (gest_p)      pend_eff = P_PLUS;
      else if (gest_m) pend_eff = P_MINUS;
      pend_d = (in_br && bus.iEnd_Frame) ? P_NONE : pend_eff;
   end

`ifdef AUTO_SLIDE_EN
   localparam int FC_W = $clog2(AUTO_FRAMES + 1);
   logic [FC_W-1:0] fc_q, fc_d;
   logic            auto_adv;

   always_comb begin
      fc_d     = fc_q;
      auto_adv = 1'b0;
      if (gest_p || gest_m) fc_d = '0;
      else if (in_br && bus.iEnd_Frame && pend_q == P_NONE) begin
         if (fc_q == FC_W'(AUTO_FRAMES - 1)) begin
            auto_adv = 1'b1;
            fc_d     = '0;
         end else begin
            fc_d = fc_q + FC_W'(1);
         end
      end
   end
   assign pend_app = auto_adv ? P_PLUS : pend_eff;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) fc_q <= '0;
      else         fc_q <= fc_d;
   end
`else
   assign pend_app = pend_eff;
`endif

   always_comb begin
      cur_d = cur_q;
      if (in_br && bus.iEnd_Frame && tot_q > TOT_W'(1)) begin
         if (pend_app == P_PLUS)
            cur_d = (TOT_W'(cur_q) == tot_q - TOT_W'(1)) ? '0 : cur_q + IDX_W'(1);
         else if (pend_app == P_MINUS)
            cur_d = (cur_q == '0) ? IDX_W'(tot_q - TOT_W'(1)) : cur_q - IDX_W'(1);
      end
   end

   // Channel k index is (cur+k) mod tot, built by an increment-and-wrap chain.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      if (k == 0) begin : g_first
         assign idx[k] = cur_d;
      end else begin : g_next
         assign idx[k] = (TOT_W'(idx[k-1]) + TOT_W'(1) >= tot_q) ? '0 : idx[k-1] + IDX_W'(1);
      end
      assign base_w[k] = ADDR_W'(idx[k]) * ADDR_W'(IMG_WORDS);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= S_IDLE;
         tot_q     <= '0;
         pix_q     <= '0;
         set_q     <= '0;
         wrmax_q   <= '0;
         cur_q     <= '0;
         pend_q    <= P_NONE;
         load_q    <= 1'b0;
         loading_q <= 1'b0;
         browse_q  <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            base_q[k] <= '0;
            max_q[k]  <= ADDR_W'(IMG_WORDS);
         end
      end else begin
         state_q   <= state_d;
         tot_q     <= tot_d;
         pix_q     <= pix_d;
         set_q     <= set_d;
         wrmax_q   <= wrmax_d;
         cur_q     <= cur_d;
         pend_q    <= pend_d;
         load_q    <= bus.iNew_Frame;
         loading_q <= (state_d == S_LOAD) || (state_d == S_SETTLE);
         browse_q  <= (state_d == S_BROWSE);
         if (bus.iEnd_Frame) begin
            for (int k = 0; k < NUM_CH; k++) begin
               base_q[k] <= base_w[k];
               max_q[k]  <= base_w[k] + ADDR_W'(IMG_WORDS);
            end
         end
      end
   end

   assign bus.oLoading     = loading_q;
   assign bus.oBrowse      = browse_q;
   assign bus.oCur_Img     = cur_q;
   assign bus.oPix_Cnt     = pix_q;
   assign bus.oWr_Max_Addr = wrmax_q;
   assign bus.oRd_Base     = base_q;
   assign bus.oRd_Max      = max_q;
   assign bus.oRd_Load     = load_q;
endmodule

// File: tb/tb_img_seq_mmu.sv
// tb_img_seq_mmu: directed bench for img_seq_mmu with a per-cycle reference model.
// Model tracks pixel count, settle deadline, image index and windows by plain arithmetic.
module tb_img_seq_mmu;
   localparam int NUM_CH = 2, IMG_W = 4, IMG_H = 2, WPP = 2, MAX_IMG = 4;
   localparam int ADDR_W = 24, SETTLE_CYC = 3, AUTO_FRAMES = 2;
   localparam int PPI = IMG_W * IMG_H;
   localparam int IW  = PPI * WPP;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   img_seq_mmu_if #(.NUM_CH(NUM_CH), .MAX_IMG(MAX_IMG), .ADDR_W(ADDR_W)) bus ();

   img_seq_mmu #(
      .NUM_CH(NUM_CH), .IMG_W(IMG_W), .IMG_H(IMG_H), .WORDS_PER_PIX(WPP),
      .MAX_IMG(MAX_IMG), .ADDR_W(ADDR_W), .SETTLE_CYC(SETTLE_CYC), .AUTO_FRAMES(AUTO_FRAMES)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n), .bus(bus)
   );

   int n_chk = 0, n_pass = 0;
   int m_tot, m_cnt, m_done, m_cyc = 0, m_cur, m_pend, m_wrmax, m_load;
   int m_base [NUM_CH];
`ifdef AUTO_SLIDE_EN
   int m_fc;
`endif

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic m_reset();
      m_tot = 0; m_cnt = 0; m_done = 0; m_cur = 0; m_pend = 0; m_wrmax = 0; m_load = 0;
      for (int k = 0; k < NUM_CH; k++) m_base[k] = 0;
`ifdef AUTO_SLIDE_EN
      m_fc = 0;
`endif
   endtask

   function automatic bit m_browse();
      return m_tot != 0 && m_cnt == m_tot * PPI && (m_cyc - m_done >= SETTLE_CYC + 1);
   endfunction

   task automatic m_step();
      bit inb;
      int g;
      inb = m_browse();
      m_cyc++;
      if (m_tot == 0) begin
         if (bus.iPix_Wr && bus.iImg_Tot != 0) begin
            m_tot   = (int'(bus.iImg_Tot) > MAX_IMG) ? MAX_IMG : int'(bus.iImg_Tot);
            m_cnt   = 1;
            m_wrmax = m_tot * IW;
            if (m_cnt == m_tot * PPI) m_done = m_cyc;
         end
      end else if (bus.iPix_Wr && m_cnt < m_tot * PPI) begin
         m_cnt++;
         if (m_cnt == m_tot * PPI) m_done = m_cyc;
      end
      if (inb) begin
         g = (bus.iGest_W && !bus.iGest_E) ? 1 : (bus.iGest_E && !bus.iGest_W) ? -1 : 0;
         if (g != 0) begin
            m_pend = g;
`ifdef AUTO_SLIDE_EN
            m_fc = 0;
`endif
         end
         if (bus.iEnd_Frame) begin
`ifdef AUTO_SLIDE_EN
            if (m_pend == 0) begin
               m_fc++;
               if (m_fc == AUTO_FRAMES) begin m_pend = 1; m_fc = 0; end
            end
`endif
            if (m_pend != 0) m_cur = (m_cur + m_pend + m_tot) % m_tot;
            m_pend = 0;
         end
      end
      if (bus.iEnd_Frame)
         for (int k = 0; k < NUM_CH; k++) m_base[k] = (m_tot == 0) ? 0 : ((m_cur + k) % m_tot) * IW;
      m_load = bus.iNew_Frame;
   endtask

   task automatic compare_all();
      chk("loading", longint'(bus.oLoading), longint'(m_tot != 0 && !m_browse()));
      chk("browse",  longint'(bus.oBrowse),  longint'(m_browse()));
      chk("cur",     longint'(bus.oCur_Img), longint'(m_cur));
      chk("pix_cnt", longint'(bus.oPix_Cnt), longint'(m_cnt));
      chk("wr_max",  longint'(bus.oWr_Max_Addr), longint'(m_wrmax));
      chk("rd_load", longint'(bus.oRd_Load), longint'(m_load));
      for (int k = 0; k < NUM_CH; k++) begin
         chk($sformatf("rd_base%0d", k), longint'(bus.oRd_Base[k*ADDR_W +: ADDR_W]), longint'(m_base[k]));
         chk($sformatf("rd_max%0d", k),  longint'(bus.oRd_Max[k*ADDR_W +: ADDR_W]),  longint'(m_base[k] + IW));
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) m_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit e, input bit w, input bit ef, input bit nf);
      bus.iGest_E = e; bus.iGest_W = w; bus.iEnd_Frame = ef; bus.iNew_Frame = nf;
      step();
      bus.iGest_E = 0; bus.iGest_W = 0; bus.iEnd_Frame = 0; bus.iNew_Frame = 0;
   endtask

   task automatic pix(input int n);
      bus.iPix_Wr = 1;
      repeat (n) step();
      bus.iPix_Wr = 0;
   endtask

   task automatic reset_dut();
      rst_n = 0;
      m_reset();
      step();
      rst_n = 1;
      step();
   endtask

   function automatic longint base_of(input int k);
      return longint'(bus.oRd_Base[k*ADDR_W +: ADDR_W]);
   endfunction
   function automatic longint max_of(input int k);
      return longint'(bus.oRd_Max[k*ADDR_W +: ADDR_W]);
   endfunction

   initial begin
      bus.iImg_Tot = 0; bus.iPix_Wr = 0; bus.iGest_E = 0; bus.iGest_W = 0;
      bus.iNew_Frame = 0; bus.iEnd_Frame = 0;
      m_reset();
      step(); step();
      chk("rst_loading", longint'(bus.oLoading), 0);
      chk("rst_browse", longint'(bus.oBrowse), 0);
      chk("rst_base0", base_of(0), 0);
      chk("rst_base1", base_of(1), 0);
      chk("rst_max0", max_of(0), 16);
      chk("rst_max1", max_of(1), 16);
      chk("rst_load", longint'(bus.oRd_Load), 0);
      rst_n = 1;
      step();

      // pixel with iImg_Tot==0 is dropped
      pix(1);
      chk("drop_pix", longint'(bus.oPix_Cnt), 0);
      drive(0, 0, 1, 0);
      chk("idle_base1", base_of(1), 0);

      // load 3 images
      bus.iImg_Tot = 3;
      pix(1);
      chk("load_rise", longint'(bus.oLoading), 1);
      chk("load_pix1", longint'(bus.oPix_Cnt), 1);
      chk("wr_max48", longint'(bus.oWr_Max_Addr), 48);
      bus.iPix_Wr = 1;
      drive(0, 1, 1, 0);
      pix(22);
      chk("load_pix24", longint'(bus.oPix_Cnt), 24);
      chk("load_gest_ign", longint'(bus.oCur_Img), 0);
      repeat (3) step();
      chk("settle_hold", longint'(bus.oLoading), 1);
      step();
      chk("settle_fall", longint'(bus.oLoading), 0);
      chk("browse_rise", longint'(bus.oBrowse), 1);
      pix(1);
      chk("pix_sat", longint'(bus.oPix_Cnt), 24);

      // wrap-around
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      chk("wrap_cur2", longint'(bus.oCur_Img), 2);
      chk("wrap_base0", base_of(0), 32);
      chk("wrap_max0", max_of(0), 48);
      chk("wrap_base1", base_of(1), 0);
      chk("wrap_max1", max_of(1), 16);
      repeat (2) begin drive(0, 1, 0, 0); drive(0, 0, 1, 0); end
      chk("fwd_cur1", longint'(bus.oCur_Img), 1);

      // gesture edge cases
      drive(1, 1, 0, 0);
      drive(0, 0, 1, 0);
      chk("both_nochg", longint'(bus.oCur_Img), 1);
      drive(0, 1, 0, 0);
      drive(1, 1, 0, 0);
      drive(0, 0, 1, 0);
      chk("both_keeps_pend", longint'(bus.oCur_Img), 2);
      drive(0, 1, 1, 0);
      chk("coincident", longint'(bus.oCur_Img), 0);
      drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 0, 1, 0);
      chk("overwrite", longint'(bus.oCur_Img), 1);

      // reload pulse
      drive(0, 0, 0, 1);
      chk("rd_load_hi", longint'(bus.oRd_Load), 1);
      step();
      chk("rd_load_lo", longint'(bus.oRd_Load), 0);

`ifdef AUTO_SLIDE_EN
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);
      chk("auto_adv", longint'(bus.oCur_Img), 2);
      drive(0, 0, 1, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      chk("auto_gest", longint'(bus.oCur_Img), 1);
      drive(0, 0, 1, 0);
      chk("auto_restart", longint'(bus.oCur_Img), 1);
      drive(0, 0, 1, 0);
      chk("auto_adv2", longint'(bus.oCur_Img), 2);
`endif

      // clamp and mid-load asynchronous reset
      reset_dut();
      bus.iImg_Tot = 9;
      pix(20);
      chk("clamp_wrmax", longint'(bus.oWr_Max_Addr), 64);
      chk("clamp_loading", longint'(bus.oLoading), 1);
      #2 rst_n = 0;
      m_reset();
      #1;
      chk("arst_loading", longint'(bus.oLoading), 0);
      chk("arst_pix", longint'(bus.oPix_Cnt), 0);
      chk("arst_wrmax", longint'(bus.oWr_Max_Addr), 0);
      chk("arst_max0", max_of(0), 16);
      step();
      rst_n = 1;
      pix(32);
      chk("clamp_pix32", longint'(bus.oPix_Cnt), 32);
      repeat (4) step();
      chk("clamp_browse", longint'(bus.oBrowse), 1);
      drive(1, 0, 1, 0);
      chk("clamp_cur3", longint'(bus.oCur_Img), 3);
      chk("clamp_base0", base_of(0), 48);
      chk("clamp_max0", max_of(0), 64);
      chk("clamp_base1", base_of(1), 0);

      // single image: index pinned at 0
      reset_dut();
      bus.iImg_Tot = 1;
      pix(8);
      repeat (4) step();
      chk("one_browse", longint'(bus.oBrowse), 1);
      drive(0, 1, 1, 0);
      chk("one_cur", longint'(bus.oCur_Img), 0);
      chk("one_base1", base_of(1), 0);
      chk("one_max1", max_of(1), 16);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
